crc16_frame_checker: RTL and testbench

CRC16_FRAME_CHECKER -- requirements
Module: crc16_frame_checker

---
 rtl/crc16_frame_checker.sv | 220 ++++++++++++++++++++++
 tb/tb_crc16_frame_checker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_frame_checker.sv
// crc16_frame_checker
// Checks framed 16-bit word streams against a trailing CRC-16/CCITT word
// (poly 0x1021, init 0xFFFF, no reflection, no final XOR, MSB first).
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   in_valid/in_sop/in_eop  - word qualifier and frame delimiters
//   in_data[15:0]           - payload word, or the CRC word when in_eop is high
//   result_valid            - one-cycle pulse, result outputs valid
//   crc_ok, len_err         - frame verdict
//   frame_len[7:0]          - payload words received, saturating at MAX_WORDS
//   calc_crc, rx_crc[15:0]  - computed and received CRC
//   proto_err               - one-cycle pulse on a framing violation
//   good_cnt, bad_cnt[15:0] - saturating frame counters
module crc16_frame_checker #(
    parameter int MAX_WORDS = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic [15:0] in_data,
    output logic        result_valid,
    output logic        crc_ok,
    output logic        len_err,
    output logic [7:0]  frame_len,
    output logic [15:0] calc_crc,
    output logic [15:0] rx_crc,
    output logic        proto_err,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2} state_t;

    typedef struct packed {
        logic        ok;
        logic        len_err;
        logic [7:0]  len;
        logic [15:0] calc;
        logic [15:0] rx;
    } result_t;

    // One full 16-bit word through the CCITT polynomial, bit 15 first.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    state_t      state, state_next;
    logic [15:0] crc, crc_next;
    logic [7:0]  len, len_next;
    logic        ovf, ovf_next;
    logic        proto_next;
    logic        start;
    // a: completion of the frame in progress (eop or abort)
    // b: completion of a one-word frame that starts and ends in this cycle
    logic        a_valid, b_valid;
    result_t     a_res, b_res;
    // A sop&eop word that aborts a frame yields two results in one cycle;
    // the second one waits here for a single cycle.
    logic        pend_valid, pend_valid_next;
    result_t     pend, pend_next;
    logic        out_valid;
    result_t     out_res;

    // Frame FSM: next state, running CRC/length and completions.
    always_comb begin
        state_next = state;
        crc_next   = crc;
        len_next   = len;
        ovf_next   = ovf;
        proto_next = 1'b0;
        start      = 1'b0;
        a_valid    = 1'b0;
        a_res      = '0;
        b_valid    = 1'b0;
        b_res      = '0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    if (in_sop) begin
                        start = 1'b1;
                    end else begin
                        proto_next = 1'b1;
                    end
                end
                RECV, DROP: begin
                    if (in_sop) begin
                        // abort: report what was collected, then restart
                        a_valid    = 1'b1;
                        a_res      = '{ok: 1'b0, len_err: ovf, len: len, calc: crc, rx: rx_crc};
                        proto_next = 1'b1;
                        start      = 1'b1;
                    end else if (in_eop) begin
                        a_valid    = 1'b1;
                        a_res      = '{ok: (crc == in_data) & ~ovf, len_err: ovf,
                                       len: len, calc: crc, rx: in_data};
                        state_next = IDLE;
                    end else if (state == RECV) begin
                        if (len == MAX_LEN) begin
                            state_next = DROP;
                            ovf_next   = 1'b1;
                        end else begin
                            crc_next = crc_step(crc, in_data);
                            len_next = len + 8'd1;
                        end
                    end else begin
                        state_next = DROP;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
            if (start) begin
                ovf_next = 1'b0;
                if (in_eop) begin
                    b_valid    = 1'b1;
                    b_res      = '{ok: (in_data == 16'hFFFF), len_err: 1'b0,
                                   len: 8'd0, calc: 16'hFFFF, rx: in_data};
                    state_next = IDLE;
                    crc_next   = 16'hFFFF;
                    len_next   = 8'd0;
                end else begin
                    state_next = RECV;
                    crc_next   = crc_step(16'hFFFF, in_data);
                    len_next   = 8'd1;
                end
            end else begin
                ovf_next = ovf_next;
            end
        end else begin
            state_next = state;
        end
    end

    // Result ordering: pending first, then current frame, then new one-word frame.
    always_comb begin
        out_valid       = pend_valid | a_valid | b_valid;
        out_res         = b_res;
        pend_valid_next = 1'b0;
        pend_next       = pend;
        if (pend_valid) begin
            out_res         = pend;
            pend_valid_next = a_valid | b_valid;
            pend_next       = a_valid ? a_res : b_res;
        end else if (a_valid) begin
            out_res         = a_res;
            pend_valid_next = b_valid;
            pend_next       = b_res;
        end else begin
            out_res = b_res;
        end
    end

    // Frame state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            crc        <= 16'hFFFF;
            len        <= 8'd0;
            ovf        <= 1'b0;
            pend_valid <= 1'b0;
            pend       <= '0;
        end else begin
            state      <= state_next;
            crc        <= crc_next;
            len        <= len_next;
            ovf        <= ovf_next;
            pend_valid <= pend_valid_next;
            pend       <= pend_next;
        end
    end

    // Registered result outputs and saturating frame counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_valid <= 1'b0;
            crc_ok       <= 1'b0;
            len_err      <= 1'b0;
            frame_len    <= 8'd0;
            calc_crc     <= 16'hFFFF;
            rx_crc       <= 16'h0000;
            proto_err    <= 1'b0;
            good_cnt     <= 16'd0;
            bad_cnt      <= 16'd0;
        end else begin
            result_valid <= out_valid;
            proto_err    <= proto_next;
            if (out_valid) begin
                crc_ok    <= out_res.ok;
                len_err   <= out_res.len_err;
                frame_len <= out_res.len;
                calc_crc  <= out_res.calc;
                rx_crc    <= out_res.rx;
                if (out_res.ok && (good_cnt != 16'hFFFF)) begin
                    good_cnt <= good_cnt + 16'd1;
                end else if (!out_res.ok && (bad_cnt != 16'hFFFF)) begin
                    bad_cnt <= bad_cnt + 16'd1;
                end else begin
                    good_cnt <= good_cnt;
                end
            end else begin
                crc_ok <= crc_ok;
            end
        end
    end

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Self-checking bench for crc16_frame_checker (MAX_WORDS = 4).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge that follows the accepting rising edge.
module tb_crc16_frame_checker;

    localparam int MAXW = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic [15:0] in_data;
    logic        result_valid;
    logic        crc_ok;
    logic        len_err;
    logic [7:0]  frame_len;
    logic [15:0] calc_crc;
    logic [15:0] rx_crc;
    logic        proto_err;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    int checks = 0;
    int errors = 0;
    int exp_good = 0;
    int exp_bad = 0;

    crc16_frame_checker #(.MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop),
        .in_eop(in_eop), .in_data(in_data), .result_valid(result_valid),
        .crc_ok(crc_ok), .len_err(len_err), .frame_len(frame_len),
        .calc_crc(calc_crc), .rx_crc(rx_crc), .proto_err(proto_err),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference CRC: byte-oriented CRC-16/CCITT-FALSE over the words, big-endian.
    function automatic logic [15:0] model_crc(input logic [15:0] words[$], input int count);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int i = 0; i < count; i++) begin
            for (int k = 0; k < 2; k++) begin
                b = (k == 0) ? words[i][15:8] : words[i][7:0];
                c = c ^ {b, 8'h00};
                for (int j = 0; j < 8; j++) begin
                    c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
                end
            end
        end
        return c;
    endfunction

    task automatic drive(input logic s, input logic e, input logic [15:0] d);
        in_valid = 1'b1;
        in_sop   = s;
        in_eop   = e;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_sop   = 1'($urandom_range(0, 1));
        in_eop   = 1'($urandom_range(0, 1));
        in_data  = 16'($urandom);
        @(negedge clk);
    endtask

    task automatic maybe_gap(input bit gaps);
        if (gaps && ($urandom_range(0, 3) == 0)) idle_cycle();
    endtask

    task automatic send_frame(input logic [15:0] pl[$], input logic [15:0] rx, input bit gaps);
        if (pl.size() == 0) begin
            drive(1'b1, 1'b1, rx);
        end else begin
            drive(1'b1, 1'b0, pl[0]);
            for (int i = 1; i < pl.size(); i++) begin
                maybe_gap(gaps);
                drive(1'b0, 1'b0, pl[i]);
            end
            maybe_gap(gaps);
            drive(1'b0, 1'b1, rx);
        end
    endtask

    task automatic test_reset();
        checks += 8;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", result_valid); end
        if (crc_ok !== 1'b0) begin errors++; $display("FAIL rst_crc_ok got %0b want 0", crc_ok); end
        if (len_err !== 1'b0) begin errors++; $display("FAIL rst_len_err got %0b want 0", len_err); end
        if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto got %0b want 0", proto_err); end
        if (frame_len !== 8'd0) begin errors++; $display("FAIL rst_len got %0d want 0", frame_len); end
        if (calc_crc !== 16'hFFFF) begin errors++; $display("FAIL rst_calc got %h want ffff", calc_crc); end
        if (rx_crc !== 16'h0000) begin errors++; $display("FAIL rst_rx got %h want 0000", rx_crc); end
        if ({good_cnt, bad_cnt} !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", good_cnt, bad_cnt); end
    endtask

    task automatic test_known_vectors();
        logic [15:0] q[$];
        q = {16'h0000};
        send_frame(q, 16'h1D0F, 1'b0);
        exp_good++;
        checks += 5;
        if (result_valid !== 1'b1) begin errors++; $display("FAIL kv1_valid got %0b want 1", result_valid); end
        if (crc_ok !== 1'b1) begin errors++; $display("FAIL kv1_ok got %0b want 1", crc_ok); end
        if (frame_len !== 8'd1) begin errors++; $display("FAIL kv1_len got %0d want 1", frame_len); end
        if (calc_crc !== 16'h1D0F) begin errors++; $display("FAIL kv1_calc got %h want 1d0f", calc_crc); end
        if (good_cnt !== 16'(exp_good)) begin errors++; $display("FAIL kv1_good got %0d want %0d", good_cnt, exp_good); end
        idle_cycle();
        checks += 2;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL kv1_pulse got %0b want 0", result_valid); end
        if (crc_ok !== 1'b1) begin errors++; $display("FAIL kv1_hold got %0b want 1", crc_ok); end

        send_frame(q, 16'h1D0E, 1'b0);
        exp_bad++;
        checks += 4;
        if (crc_ok !== 1'b0) begin errors++; $display("FAIL kv2_ok got %0b want 0", crc_ok); end
        if (calc_crc !== 16'h1D0F) begin errors++; $display("FAIL kv2_calc got %h want 1d0f", calc_crc); end
        if (rx_crc !== 16'h1D0E) begin errors++; $display("FAIL kv2_rx got %h want 1d0e", rx_crc); end
        if (bad_cnt !== 16'(exp_bad)) begin errors++; $display("FAIL kv2_bad got %0d want %0d", bad_cnt, exp_bad); end

        q = {};
        send_frame(q, 16'hFFFF, 1'b0);
        exp_good++;
        checks += 3;
        if (result_valid !== 1'b1 || crc_ok !== 1'b1) begin errors++; $display("FAIL kv3_ok got v=%0b ok=%0b want 1/1", result_valid, crc_ok); end
        if (frame_len !== 8'd0) begin errors++; $display("FAIL kv3_len got %0d want 0", frame_len); end
        if (calc_crc !== 16'hFFFF) begin errors++; $display("FAIL kv3_calc got %h want ffff", calc_crc); end
    endtask

    task automatic test_overflow();
        logic [15:0] q[$];
        logic [15:0] nw;
        q = {};
        for (int i = 0; i < 6; i++) q.push_back(16'($urandom));
        send_frame(q, model_crc(q, MAXW), 1'b0);
        exp_bad++;
        checks += 4;
        if (len_err !== 1'b1) begin errors++; $display("FAIL ovf_len_err got %0b want 1", len_err); end
        if (crc_ok !== 1'b0) begin errors++; $display("FAIL ovf_ok got %0b want 0", crc_ok); end
        if (frame_len !== 8'(MAXW)) begin errors++; $display("FAIL ovf_len got %0d want %0d", frame_len, MAXW); end
        if (bad_cnt !== 16'(exp_bad)) begin errors++; $display("FAIL ovf_bad got %0d want %0d", bad_cnt, exp_bad); end

        // abort while dropping
        drive(1'b1, 1'b0, q[0]);
        for (int i = 1; i < 6; i++) drive(1'b0, 1'b0, q[i]);
        nw = 16'($urandom);
        drive(1'b1, 1'b0, nw);
        exp_bad++;
        checks += 3;
        if (result_valid !== 1'b1 || proto_err !== 1'b1) begin errors++; $display("FAIL dabort_pulse got v=%0b p=%0b want 1/1", result_valid, proto_err); end
        if (len_err !== 1'b1 || crc_ok !== 1'b0) begin errors++; $display("FAIL dabort_flags got le=%0b ok=%0b want 1/0", len_err, crc_ok); end
        if (frame_len !== 8'(MAXW)) begin errors++; $display("FAIL dabort_len got %0d want %0d", frame_len, MAXW); end
        q = {nw};
        drive(1'b0, 1'b1, model_crc(q, 1));
        exp_good++;
        checks += 2;
        if (result_valid !== 1'b1 || crc_ok !== 1'b1 || len_err !== 1'b0) begin errors++; $display("FAIL dabort_next got v=%0b ok=%0b le=%0b want 1/1/0", result_valid, crc_ok, len_err); end
        if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin errors++; $display("FAIL dabort_cnt got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); end
    endtask

    task automatic test_abort();
        logic [15:0] a0, a1, b0, b1;
        logic [15:0] qb[$];
        a0 = 16'($urandom); a1 = 16'($urandom); b0 = 16'($urandom); b1 = 16'($urandom);
        drive(1'b1, 1'b0, a0);
        drive(1'b0, 1'b0, a1);
        drive(1'b1, 1'b0, b0);
        exp_bad++;
        checks += 3;
        if (result_valid !== 1'b1 || proto_err !== 1'b1) begin errors++; $display("FAIL abort_pulse got v=%0b p=%0b want 1/1", result_valid, proto_err); end
        if (crc_ok !== 1'b0 || len_err !== 1'b0) begin errors++; $display("FAIL abort_flags got ok=%0b le=%0b want 0/0", crc_ok, len_err); end
        if (frame_len !== 8'd2) begin errors++; $display("FAIL abort_len got %0d want 2", frame_len); end
        drive(1'b0, 1'b0, b1);
        checks += 1;
        if (result_valid !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL abort_mid got v=%0b p=%0b want 0/0", result_valid, proto_err); end
        qb = {b0, b1};
        drive(1'b0, 1'b1, model_crc(qb, 2));
        exp_good++;
        checks += 3;
        if (result_valid !== 1'b1 || crc_ok !== 1'b1) begin errors++; $display("FAIL abortb_ok got v=%0b ok=%0b want 1/1", result_valid, crc_ok); end
        if (frame_len !== 8'd2 || proto_err !== 1'b0) begin errors++; $display("FAIL abortb_len got %0d p=%0b want 2/0", frame_len, proto_err); end
        if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin errors++; $display("FAIL abort_cnt got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); end

        // abort by a single-word frame: both results are reported, in order
        drive(1'b1, 1'b0, a0);
        drive(1'b1, 1'b1, 16'hFFFF);
        exp_bad++;
        checks += 1;
        if (result_valid !== 1'b1 || crc_ok !== 1'b0 || frame_len !== 8'd1) begin errors++; $display("FAIL abort1_first got v=%0b ok=%0b len=%0d want 1/0/1", result_valid, crc_ok, frame_len); end
        idle_cycle();
        exp_good++;
        checks += 2;
        if (result_valid !== 1'b1 || crc_ok !== 1'b1 || frame_len !== 8'd0) begin errors++; $display("FAIL abort1_second got v=%0b ok=%0b len=%0d want 1/1/0", result_valid, crc_ok, frame_len); end
        if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin errors++; $display("FAIL abort1_cnt got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); end
        idle_cycle();
    endtask

    task automatic test_stray();
        drive(1'b0, 1'b0, 16'($urandom));
        checks += 1;
        if (proto_err !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL stray got p=%0b v=%0b want 1/0", proto_err, result_valid); end
        idle_cycle();
        checks += 2;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL stray_pulse got %0b want 0", proto_err); end
        if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin errors++; $display("FAIL stray_cnt got %0d/%0d want %0d/%0d", good_cnt, bad_cnt, exp_good, exp_bad); end
    endtask

    task automatic test_random_frames(input int n_frames);
        logic [15:0] q[$];
        logic [15:0] rx, exp_calc;
        int          n;
        bit          exp_le, exp_ok;
        for (int f = 0; f < n_frames; f++) begin
            n = $urandom_range(0, 6);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(16'($urandom));
            exp_le   = (n > MAXW);
            exp_calc = model_crc(q, exp_le ? MAXW : n);
            rx       = ($urandom_range(0, 1) == 1) ? exp_calc : 16'($urandom);
            exp_ok   = !exp_le && (rx == exp_calc);
            if (exp_ok) exp_good++; else exp_bad++;
            send_frame(q, rx, 1'b1);
            checks += 5;
            if (result_valid !== 1'b1) begin errors++; $display("FAIL rnd%0d_valid got %0b want 1", f, result_valid); end
            if (crc_ok !== exp_ok || len_err !== exp_le) begin errors++; $display("FAIL rnd%0d_flags got ok=%0b le=%0b want %0b/%0b", f, crc_ok, len_err, exp_ok, exp_le); end
            if (frame_len !== 8'(exp_le ? MAXW : n)) begin errors++; $display("FAIL rnd%0d_len got %0d want %0d", f, frame_len, exp_le ? MAXW : n); end
            if (rx_crc !== rx || (!exp_le && calc_crc !== exp_calc)) begin errors++; $display("FAIL rnd%0d_crc got calc=%h rx=%h want %h/%h", f, calc_crc, rx_crc, exp_calc, rx); end
            if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin errors++; $display("FAIL rnd%0d_cnt got %0d/%0d want %0d/%0d", f, good_cnt, bad_cnt, exp_good, exp_bad); end
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] q[$];
        drive(1'b1, 1'b0, 16'($urandom));
        drive(1'b0, 1'b0, 16'($urandom));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_good = 0;
        exp_bad  = 0;
        @(negedge clk);
        test_reset();
        q = {16'h0000};
        send_frame(q, 16'h1D0F, 1'b0);
        exp_good++;
        checks += 1;
        if (result_valid !== 1'b1 || crc_ok !== 1'b1 || good_cnt !== 16'(exp_good)) begin errors++; $display("FAIL postrst got v=%0b ok=%0b good=%0d want 1/1/%0d", result_valid, crc_ok, good_cnt, exp_good); end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_known_vectors();
        test_overflow();
        test_abort();
        test_stray();
        test_random_frames(60);
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
